// File: rtl/serial8_collector.sv
// -----------------------------------------------------------------------------
// serial8_collector
//
// Bit-serial to 8-bit parallel collector feeding the 8-input AND reduction
// stage. Single bits arrive over a valid/ready handshake, are assembled into a
// byte, and the completed byte is presented on a valid/ready output handshake.
// While the byte is held it drives the reduction inputs
// (a = byte_out[0] ... h = byte_out[7]).
//
// Parameters:
//   LSB_FIRST  1: first accepted bit lands in byte_out[0]
//              0: first accepted bit lands in byte_out[7]
//
// Ports:
//   clock      in   1  rising-edge clock
//   reset      in   1  asynchronous, active-high reset
//   clear      in   1  synchronous abort, drops partial or held byte
//   in_valid   in   1  in_bit is valid this cycle
//   in_bit     in   1  serial data bit
//   in_ready   out  1  collector accepts a bit this cycle (COLLECT)
//   out_valid  out  1  byte_out holds a complete byte (HOLD)
//   out_ready  in   1  downstream takes the byte this cycle
//   byte_out   out  8  assembled byte, stable while out_valid = 1
//   count      out  3  bits accepted so far in the current byte
// -----------------------------------------------------------------------------
module serial8_collector #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] byte_out,
  output logic [2:0] count
);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [7:0] byte_q, byte_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;

  logic       in_xfer_s;
  logic       out_xfer_s;
  logic       last_bit_s;

  // Bit position inside the byte for the bit accepted at a given count.
  function automatic logic [2:0] bit_slot(input logic [2:0] cnt);
    if (LSB_FIRST) begin
      return cnt;
    end else begin
      return 3'd7 - cnt;
    end
  endfunction

  // Handshake qualifiers. Both use the registered state decodes, so the
  // cycle that completes an output transfer still has in_ready low and no
  // bit can slip in on that same edge.
  always_comb begin
    in_xfer_s  = in_valid & in_ready_q;
    out_xfer_s = out_valid_q & out_ready;
    last_bit_s = (count_q == 3'd7);
  end

  // Next-state logic: clear wins over every transfer in the same cycle.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_COLLECT;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (in_xfer_s && last_bit_s) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_COLLECT;
          end
        end
        ST_HOLD: begin
          if (out_xfer_s) begin
            state_d = ST_COLLECT;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_COLLECT;
        end
      endcase
    end
  end

  // Datapath: write the accepted bit into its slot and advance the count.
  // Slots not yet rewritten keep their previous contents; the count wraps
  // from 7 to 0 on the eighth bit, matching the move to HOLD.
  always_comb begin
    count_d = count_q;
    byte_d  = byte_q;
    if (clear) begin
      count_d = 3'd0;
      byte_d  = 8'h00;
    end else if (in_xfer_s) begin
      byte_d[bit_slot(count_q)] = in_bit;
      count_d                   = count_q + 3'd1;
    end else begin
      count_d = count_q;
      byte_d  = byte_q;
    end
  end

  // Output decode of the next state, registered so the handshake outputs
  // come straight from flops.
  always_comb begin
    in_ready_d  = 1'b1;
    out_valid_d = 1'b0;
    case (state_d)
      ST_COLLECT: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
      ST_HOLD: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
      end
      default: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_COLLECT;
      count_q     <= 3'd0;
      byte_q      <= 8'h00;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      byte_q      <= byte_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Port drive.
  always_comb begin
    in_ready  = in_ready_q;
    out_valid = out_valid_q;
    byte_out  = byte_q;
    count     = count_q;
  end

endmodule

// File: tb/tb_serial8_collector.sv
module tb_serial8_collector;

  logic       clock;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic       in_bit;
  logic       out_ready;

  logic       in_ready_l, out_valid_l;
  logic [7:0] byte_l;
  logic [2:0] count_l;
  logic       in_ready_m, out_valid_m;
  logic [7:0] byte_m;
  logic [2:0] count_m;

  int n_run;
  int n_fail;

  // Reference model: bits of the current byte in arrival order, hold flag
  // and the last completed byte interpreted both ways.
  bit         m_bits[$];
  bit         m_hold;
  logic [7:0] m_byte_l;
  logic [7:0] m_byte_m;

  serial8_collector #(.LSB_FIRST(1'b1)) dut_lsb (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready_l),
    .out_valid(out_valid_l), .out_ready(out_ready),
    .byte_out(byte_l), .count(count_l)
  );

  serial8_collector #(.LSB_FIRST(1'b0)) dut_msb (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready_m),
    .out_valid(out_valid_m), .out_ready(out_ready),
    .byte_out(byte_m), .count(count_m)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    m_bits.delete();
    m_hold = 1'b0;
  endtask

  // Drive one cycle, advance the model across the edge, settle 1 time unit.
  task automatic step(input logic v, input logic b, input logic r, input logic c);
    logic [7:0] acc_l;
    logic [7:0] acc_m;
    in_valid  = v;
    in_bit    = b;
    out_ready = r;
    clear     = c;
    @(posedge clock);
    if (c) begin
      model_reset();
    end else if (m_hold) begin
      if (r) m_hold = 1'b0;
    end else if (v) begin
      m_bits.push_back(b);
      if (m_bits.size() == 8) begin
        acc_l = 8'h00;
        acc_m = 8'h00;
        for (int i = 0; i < 8; i++) begin
          acc_l = acc_l | (8'(m_bits[i]) << i);
          acc_m = acc_m | (8'(m_bits[i]) << (7 - i));
        end
        m_byte_l = acc_l;
        m_byte_m = acc_m;
        m_bits.delete();
        m_hold = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    n_run++;
    if (in_ready_l !== 1'b1 || in_ready_m !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b/%b expected 1", in_ready_l, in_ready_m);
    end
    n_run++;
    if (out_valid_l !== 1'b0 || out_valid_m !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b/%b expected 0", out_valid_l, out_valid_m);
    end
    n_run++;
    if (count_l !== 3'd0 || byte_l !== 8'h00 || count_m !== 3'd0 || byte_m !== 8'h00) begin
      n_fail++; $display("FAIL reset_data: got count %0d byte %h expected 0/00", count_l, byte_l);
    end
    #2 reset = 1'b0;
  endtask

  task automatic test_pattern();
    logic [7:0] pat;
    pat = 8'b0100_1101;  // bits 1,0,1,1,0,0,1,0 in arrival order
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pat[i], 1'b0, 1'b0);
      n_run++;
      if (count_l !== 3'((i + 1) % 8)) begin
        n_fail++; $display("FAIL pattern_count[%0d]: got %0d expected %0d", i, count_l, (i + 1) % 8);
      end
    end
    n_run++;
    if (out_valid_l !== 1'b1 || in_ready_l !== 1'b0) begin
      n_fail++; $display("FAIL pattern_hold: got out_valid %b in_ready %b expected 1/0", out_valid_l, in_ready_l);
    end
    // Hold for 5 cycles; in_valid is kept high to show it is ignored.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, i[0], 1'b0, 1'b0);
      n_run++;
      if (byte_l !== 8'h4D || out_valid_l !== 1'b1) begin
        n_fail++; $display("FAIL pattern_lsb[%0d]: got %h/%b expected 4d/1", i, byte_l, out_valid_l);
      end
      n_run++;
      if (byte_m !== 8'hB2 || out_valid_m !== 1'b1) begin
        n_fail++; $display("FAIL pattern_msb[%0d]: got %h/%b expected b2/1", i, byte_m, out_valid_m);
      end
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_run++;
    if (out_valid_l !== 1'b0 || in_ready_l !== 1'b1 || count_l !== 3'd0) begin
      n_fail++; $display("FAIL pattern_release: got out_valid %b in_ready %b count %0d expected 0/1/0",
                         out_valid_l, in_ready_l, count_l);
    end
  endtask

  task automatic test_back_to_back();
    int hi_cycles;
    hi_cycles = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    n_run++;
    if (out_valid_l !== 1'b1 || byte_l !== 8'hFF) begin
      n_fail++; $display("FAIL b2b_ff: got %b/%h expected 1/ff", out_valid_l, byte_l);
    end
    hi_cycles++;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    if (out_valid_l === 1'b1) hi_cycles++;
    n_run++;
    if (hi_cycles !== 1) begin
      n_fail++; $display("FAIL b2b_one_cycle: got %0d cycles expected 1", hi_cycles);
    end
    n_run++;
    if (count_l !== 3'd0 || in_ready_l !== 1'b1) begin
      n_fail++; $display("FAIL b2b_no_bypass: got count %0d in_ready %b expected 0/1", count_l, in_ready_l);
    end
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    n_run++;
    if (out_valid_l !== 1'b1 || byte_l !== 8'h00 || byte_m !== 8'h00) begin
      n_fail++; $display("FAIL b2b_zero: got %b/%h/%h expected 1/00/00", out_valid_l, byte_l, byte_m);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      n_run++;
      if (count_l !== 3'd3 || in_ready_l !== 1'b1) begin
        n_fail++; $display("FAIL stall_count[%0d]: got %0d/%b expected 3/1", i, count_l, in_ready_l);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      n_run++;
      if (out_valid_l !== m_hold) begin
        n_fail++; $display("FAIL stall_latency[%0d]: got %b expected %b", i, out_valid_l, m_hold);
      end
    end
    n_run++;
    if (byte_l !== m_byte_l || byte_m !== m_byte_m) begin
      n_fail++; $display("FAIL stall_byte: got %h/%h expected %h/%h", byte_l, byte_m, m_byte_l, m_byte_m);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_clear();
    logic [7:0] a5;
    a5 = 8'hA5;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_run++;
    if (count_l !== 3'd0 || byte_l !== 8'h00 || byte_m !== 8'h00 || in_ready_l !== 1'b1) begin
      n_fail++; $display("FAIL clear_state: got count %0d byte %h/%h expected 0/00/00", count_l, byte_l, byte_m);
    end
    for (int i = 0; i < 8; i++) step(1'b1, a5[i], 1'b0, 1'b0);
    n_run++;
    if (out_valid_l !== 1'b1 || byte_l !== 8'hA5) begin
      n_fail++; $display("FAIL clear_a5: got %b/%h expected 1/a5", out_valid_l, byte_l);
    end
    // clear in HOLD also beats a simultaneous output transfer.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    n_run++;
    if (out_valid_l !== 1'b0 || byte_l !== 8'h00 || count_l !== 3'd0) begin
      n_fail++; $display("FAIL clear_hold: got %b/%h/%0d expected 0/00/0", out_valid_l, byte_l, count_l);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] b3c;
    b3c = 8'h3C;
    for (int i = 0; i < 8; i++) step(1'b1, b3c[i], 1'b0, 1'b0);
    n_run++;
    if (out_valid_l !== 1'b1 || byte_l !== 8'h3C) begin
      n_fail++; $display("FAIL areset_pre: got %b/%h expected 1/3c", out_valid_l, byte_l);
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_run++;
    if (in_ready_l !== 1'b1 || out_valid_l !== 1'b0 || count_l !== 3'd0 || byte_l !== 8'h00) begin
      n_fail++; $display("FAIL areset_now: got in_ready %b out_valid %b count %0d byte %h expected 1/0/0/00",
                         in_ready_l, out_valid_l, count_l, byte_l);
    end
    #2 reset = 1'b0;
    model_reset();
    // First bit after reset must land in bit 0.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    n_run++;
    if (out_valid_l !== 1'b1 || byte_l !== 8'h01 || byte_m !== 8'h80) begin
      n_fail++; $display("FAIL areset_first_bit: got %b/%h/%h expected 1/01/80", out_valid_l, byte_l, byte_m);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic v, b, r, c;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      b = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 31) == 0);
      step(v, b, r, c);
      n_run++;
      if (in_ready_l !== !m_hold || out_valid_l !== m_hold ||
          in_ready_m !== !m_hold || out_valid_m !== m_hold) begin
        n_fail++; $display("FAIL rand_hs[%0d]: got %b%b/%b%b expected %b%b", i,
                           in_ready_l, out_valid_l, in_ready_m, out_valid_m, !m_hold, m_hold);
      end
      n_run++;
      if (count_l !== 3'(m_bits.size()) || count_m !== 3'(m_bits.size())) begin
        n_fail++; $display("FAIL rand_count[%0d]: got %0d/%0d expected %0d", i, count_l, count_m, m_bits.size());
      end
      if (m_hold) begin
        n_run++;
        if (byte_l !== m_byte_l || byte_m !== m_byte_m) begin
          n_fail++; $display("FAIL rand_byte[%0d]: got %h/%h expected %h/%h", i, byte_l, byte_m, m_byte_l, m_byte_m);
        end
      end
    end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    test_reset();
    test_pattern();
    test_back_to_back();
    test_stall();
    test_clear();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
